// File: rtl/pc_fetch_ctrl.sv
// Program counter and instruction-fetch controller: registers the jump-mux next PC,
// runs the imem grant/valid handshake and holds the fetched word until the core commits.
module pc_fetch_ctrl #(
  parameter int                 WIDTH    = 32,
  parameter logic [WIDTH-1:0]   RESET_PC = '0
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [WIDTH-1:0] i_next_pc,
  input  logic             i_pc_load,
  input  logic             i_stall,
  output logic             o_imem_req,
  output logic [WIDTH-1:0] o_imem_addr,
  input  logic             i_imem_gnt,
  input  logic             i_imem_rvalid,
  input  logic [WIDTH-1:0] i_imem_rdata,
  output logic [WIDTH-1:0] o_pc,
  output logic [WIDTH-1:0] o_pc_plus4,
  output logic [WIDTH-1:0] o_instr,
  output logic             o_instr_valid,
  output logic             o_misaligned,
  output logic [31:0]      o_retire_cnt
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_WAIT,
    S_EXEC,
    S_TRAP
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] pc_q, pc_d;
  logic [WIDTH-1:0] instr_q, instr_d;
  logic [31:0]      retire_cnt_q, retire_cnt_d;

  logic commit;
  assign commit = (state_q == S_EXEC) && i_pc_load && !i_stall;

  // NOTE: every always_comb target is given its hold value first, so no path can infer a latch.
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    instr_d      = instr_q;
    retire_cnt_d = retire_cnt_q;
    case (state_q)
      S_IDLE:  state_d = S_FETCH;
      S_FETCH: begin
        // Data returned without a grant belongs to no request of ours.
        if (i_imem_gnt && i_imem_rvalid) begin
          instr_d = i_imem_rdata;
          state_d = S_EXEC;
        end else if (i_imem_gnt) begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (i_imem_rvalid) begin
          instr_d = i_imem_rdata;
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        if (commit) begin
          // The bad target is still loaded so the trap handler can see it.
          pc_d         = i_next_pc;
          retire_cnt_d = retire_cnt_q + 32'd1;
          state_d      = (i_next_pc[1:0] == 2'b00) ? S_FETCH : S_TRAP;
        end
      end
      S_TRAP:  state_d = S_TRAP;
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q      <= S_IDLE;
      pc_q         <= RESET_PC;
      instr_q      <= '0;
      retire_cnt_q <= '0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      instr_q      <= instr_d;
      retire_cnt_q <= retire_cnt_d;
    end
  end

  // Handshake and status outputs decode the state register only.
  assign o_imem_req    = (state_q == S_FETCH);
  assign o_instr_valid = (state_q == S_EXEC);
  assign o_misaligned  = (state_q == S_TRAP);

  assign o_pc          = pc_q;
  assign o_imem_addr   = pc_q;
  assign o_pc_plus4    = pc_q + WIDTH'(4);
  assign o_instr       = instr_q;
  assign o_retire_cnt  = retire_cnt_q;

endmodule

// File: doc/pc_fetch_ctrl.md
# pc_fetch_ctrl

Program-counter and instruction-fetch controller for the MIPS-32 core. It registers the next-PC value selected by the jump-select stage and drives the instruction-memory request with a grant/valid handshake. It holds the fetched instruction stable for the decode/execute datapath until the core commits, then loads the new PC. It sits directly downstream of the jump mux (consumes `o_mux5`) and upstream of instruction decode.

## Interface
- `WIDTH`, 32, PC/address/instruction width.
- `RESET_PC`, 32'h0000_0000, PC value after reset; must be word-aligned.
- `i_clk` input 1: single clock; all state updates on the rising edge.
- `i_rst` input 1: asynchronous, active-high reset.
- `i_next_pc` input WIDTH: next PC from the jump mux (`o_mux5`).
- `i_pc_load` input 1: core commit; load `i_next_pc` (honoured only in EXEC).
- `i_stall` input 1: blocks commit while high.
- `o_imem_req` output 1: instruction-memory request.
- `o_imem_addr` output WIDTH: request address, equal to `o_pc`.
- `i_imem_gnt` input 1: memory accepted the request.
- `i_imem_rvalid` input 1: `i_imem_rdata` is valid this cycle.
- `i_imem_rdata` input WIDTH: returned instruction word.
- `o_pc` output WIDTH: current PC register.
- `o_pc_plus4` output WIDTH: `o_pc + 4`, modulo 2^WIDTH.
- `o_instr` output WIDTH: registered instruction.
- `o_instr_valid` output 1: `o_instr` is valid; high only in EXEC.
- `o_misaligned` output 1: sticky trap flag.
- `o_retire_cnt` output 32: number of committed instructions; wraps.

## Operation
- States: IDLE, FETCH, WAIT, EXEC, TRAP.
- IDLE: entered on reset. Moves to FETCH on the next edge, unconditionally.
- FETCH: `o_imem_req`=1.
  - `i_imem_gnt` and `i_imem_rvalid` both high: capture `i_imem_rdata` into `o_instr`, go to EXEC.
  - `i_imem_gnt` alone: go to WAIT.
  - `i_imem_rvalid` without grant: ignored.
- WAIT: `o_imem_req`=0. On `i_imem_rvalid`, capture `i_imem_rdata` and go to EXEC. Otherwise stay in WAIT indefinitely.
- EXEC: `o_instr_valid`=1 and `o_instr` is held stable.
  - `i_pc_load`=1 and `i_stall`=0: `o_pc` <= `i_next_pc`, `o_retire_cnt` += 1.
    - If `i_next_pc[1:0]`==0, go to FETCH.
    - Otherwise go to TRAP. `o_pc` still takes the misaligned value so the bad target is visible.
  - `i_stall`=1: hold PC, instruction and counter, even if `i_pc_load`=1.
- TRAP: `o_misaligned`=1, no requests, `o_instr_valid`=0. Only reset exits TRAP.
- `i_pc_load` outside EXEC is ignored. `i_next_pc` is sampled only on a commit edge.
- `o_pc_plus4` is combinational from `o_pc`; 32'hFFFF_FFFC + 4 = 0.
- `o_retire_cnt` wraps from 32'hFFFF_FFFF to 0.

## Timing
- Reset values: state IDLE, `o_pc`=RESET_PC, `o_instr`=0, `o_instr_valid`=0, `o_imem_req`=0, `o_misaligned`=0, `o_retire_cnt`=0, `o_pc_plus4`=RESET_PC+4.
- Reset asserted mid-handshake (WAIT or EXEC) aborts immediately. Any `i_imem_rvalid` that arrives after reset releases is dropped, because IDLE/FETCH ignore data without a grant.
- `o_imem_req`, `o_instr_valid` and `o_misaligned` are pure decodes of the state register; there is no combinational path from any input.
- Minimum fetch latency: reset release → req in the 2nd cycle. With zero-wait memory (gnt+rvalid same cycle), EXEC follows on the next cycle.
- Commit-to-next-request: 1 cycle (EXEC → FETCH).
- Steady state with zero-wait memory and immediate commit: one instruction per 2 cycles.
- `o_imem_addr` is stable for the whole time `o_imem_req` is high.

## Test plan
- Reset to RESET_PC=0, memory grants with rvalid in the same cycle, `i_pc_load`=1 every EXEC, `i_next_pc`=`o_pc_plus4`:
  - PC sequence must be 0, 4, 8, C.
  - `o_retire_cnt`=4 after 4 commits.
  - `o_instr` must match the memory word at each address.
- Grant in cycle N, rvalid in cycle N+3 with data 32'h2008_0005: state stays WAIT and `o_imem_req`=0 for 3 cycles, then `o_instr`=32'h2008_0005 with `o_instr_valid`=1.
- In EXEC hold `i_stall`=1 with `i_pc_load`=1 for 5 cycles: PC, instruction and counter are unchanged. Drop the stall: PC loads `i_next_pc`=32'h0040_0020 on that edge.
- Commit with `i_next_pc`=32'h0000_0012:
  - `o_pc`=32'h12 and `o_misaligned`=1.
  - No further `o_imem_req`.
  - Only `i_rst` clears it; after reset `o_pc` returns to RESET_PC.
- Assert `i_rst` asynchronously in WAIT, then return rvalid after release: the data is not captured and the outputs hold their reset values. Also preload PC 32'hFFFF_FFFC and verify `o_pc_plus4`=0.
